claim_grid_scanner: RTL and testbench
=====================================

# claim_grid_scanner

Parametrised fabric-claim scanner for the day-3 datapath. It walks every cell of a GRID_W × GRID_H grid and, for each cell, every claim held in an external claim ROM. It reports two results: the number of cells covered by at least MIN_COVER claims, and the lowest-index claim that overlaps no other claim. A start/done handshake frames each run, so one instance serves both puzzle parts and any grid size.

## Interface
Parameters:
- GRID_W, 1000, grid columns
- GRID_H, 1000, grid rows
- N_CLAIMS, 1236, number of claims in the ROM
- COORD_W, 10, width of each claim field and of the x/y counters
- MIN_COVER, 2, coverage threshold for counting a cell (≥1)
- CNT_W, 20, width of the overlap count

Ports:
- clk  in  1  rising-edge clock; one clock for the whole block
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; honoured only in IDLE
- rom_addr  out  $clog2(N_CLAIMS)  claim index
- rom_data  in  4*COORD_W  {x, y, w, h}, valid one cycle after rom_addr
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse; results valid from this cycle
- overlaps  out  CNT_W  number of cells with coverage ≥ MIN_COVER
- intact_id  out  $clog2(N_CLAIMS)  lowest claim with no overlap
- intact_valid  out  1  intact_id is meaningful

## Operation
- FSM states: IDLE, SCAN, DRAIN, FIND, DONE. Transitions: IDLE →(start) SCAN → DRAIN → FIND → DONE → IDLE.
- Start acceptance clears overlaps, intact_valid, intact_id and all N_CLAIMS overlap flags.
- SCAN order: y outer, x middle, claim index inner. One claim address is issued per cycle.
- Hit test: cx ≤ x < cx+w and cy ≤ y < cy+h, computed at COORD_W+1 bits so the sum cannot wrap. Claims extending past the grid are clipped naturally. Claims with w=0 or h=0 never hit.
- Per-cell hit counter saturates at MIN_COVER. At the cell's last claim, overlaps increments when coverage ≥ MIN_COVER; it saturates at all-ones.
- Overlap marking always uses a coverage of 2, independent of MIN_COVER:
  - the first hitting claim's id is held;
  - on the second hit, both the held claim and the current claim are flagged;
  - on the third and later hits, the current claim is flagged.
- DRAIN retires the final compare in the one-cycle ROM pipeline.
- FIND scans the flags from index 0, one per cycle. It records the first clear flag as intact_id and sets intact_valid. If every flag is set, intact_valid stays 0 and intact_id stays 0.
- DONE pulses done for one cycle, then the FSM returns to IDLE. overlaps, intact_id and intact_valid hold until the next accepted start.
- A start asserted in any state other than IDLE is ignored; it is not queued.

## Timing
- Reset values: busy=0, done=0, overlaps=0, intact_id=0, intact_valid=0, rom_addr=0. The FSM resets to IDLE and all flags clear.
- Assertion of rst_n low mid-run aborts the run immediately. No done pulse is produced.
- ROM read latency is exactly 1 cycle. The address is registered together with its x, y and id so that rom_data is compared against matching coordinates.
- Let the start be accepted at edge k, and let S = GRID_W*GRID_H*N_CLAIMS.
  - SCAN occupies cycles k+1 … k+S.
  - DRAIN is 1 cycle.
  - FIND is N_CLAIMS cycles.
  - done is high in cycle k+S+N_CLAIMS+2.
  - busy falls in that same cycle.
- Cell wrap-around:
  - at claim N_CLAIMS-1, x increments;
  - at x = GRID_W-1, x returns to 0 and y increments;
  - at the last cell (GRID_W-1, GRID_H-1), SCAN exits to DRAIN.
- When a flag update (from a second or later hit) and a new cell boundary occur in the same cycle, both take effect; the per-cell hit counter restarts at the new cell.

## Structure
- claim_pkg holds:
  - claim_t, a packed struct {x, y, w, h} of COORD_W-bit fields;
  - the FSM state enum;
  - the clog2-derived index width helper.
- The hit test lives in one combinational sub-module, claim_contains, which takes claim_t, x and y and returns hit.
- The flag vector and FIND scan stay inline.

## Test plan
- Overlapping pair with a disjoint claim:
  - setup: GRID 8×8, claims {1,3,4,4}, {3,1,4,4}, {5,5,2,2};
  - stimulus: start;
  - response: overlaps=4, intact_valid=1, intact_id=2.
- Same claims with MIN_COVER=1: overlaps=32 (the covered area), intact_id=2.
- Single claim {6,6,4,4} on an 8×8 grid, partly off-grid: overlaps=0, intact_id=0, intact_valid=1. Cells (6..7, 6..7) are hit, so a MIN_COVER=1 run gives overlaps=4.
- All claims identical {0,0,2,2}, N_CLAIMS=3: overlaps=4, intact_valid=0.
- Handshake and latency:
  - start pulsed mid-SCAN is ignored; done arrives exactly S+N_CLAIMS+2 cycles after the original start;
  - a second start after done reproduces identical results.
- rst_n dropped mid-SCAN: all outputs read 0 while rst_n is low. A subsequent start gives the same results as a clean run.

Source files
------------

// File: rtl/claim_grid_scanner_pkg.sv
// Shared types for the claim grid scanner: claim record, FSM state
// encoding and the index-width helper used for claim ids.
package claim_pkg;

    // Widest claim field the datapath carries; narrower COORD_W values
    // are zero-extended into it, so the hit test never wraps.
    localparam int COORD_MAX_W = 16;

    typedef struct packed {
        logic [COORD_MAX_W-1:0] x;
        logic [COORD_MAX_W-1:0] y;
        logic [COORD_MAX_W-1:0] w;
        logic [COORD_MAX_W-1:0] h;
    } claim_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        FIND,
        DONE
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/claim_contains.sv
// Combinational hit test: is cell (x, y) inside the claim rectangle?
// Ports: claim (rectangle), x/y (cell), hit (cell is covered).
module claim_contains
    import claim_pkg::*;
(
    input  claim_t                 claim,
    input  logic [COORD_MAX_W-1:0] x,
    input  logic [COORD_MAX_W-1:0] y,
    output logic                   hit
);

    // One extra bit so x+w / y+h cannot wrap; w=0 or h=0 gives
    // an empty interval and therefore never hits.
    logic [COORD_MAX_W:0] xe;
    logic [COORD_MAX_W:0] ye;
    logic [COORD_MAX_W:0] x_end;
    logic [COORD_MAX_W:0] y_end;

    assign xe    = {1'b0, x};
    assign ye    = {1'b0, y};
    assign x_end = {1'b0, claim.x} + {1'b0, claim.w};
    assign y_end = {1'b0, claim.y} + {1'b0, claim.h};

    assign hit = (x >= claim.x) && (xe < x_end)
              && (y >= claim.y) && (ye < y_end);

endmodule

// File: rtl/claim_grid_scanner.sv
// Walks every grid cell against every claim in an external ROM, counting
// cells with coverage >= MIN_COVER and finding the lowest non-overlapping
// claim.
// Ports: clk, rst_n (async, active low), start (request in IDLE),
// rom_addr/rom_data (1-cycle ROM), busy, done (pulse), overlaps,
// intact_id, intact_valid.
module claim_grid_scanner
    import claim_pkg::*;
#(
    parameter int GRID_W    = 1000,
    parameter int GRID_H    = 1000,
    parameter int N_CLAIMS  = 1236,
    parameter int COORD_W   = 10,
    parameter int MIN_COVER = 2,
    parameter int CNT_W     = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic [idx_w(N_CLAIMS)-1:0]   rom_addr,
    input  logic [4*COORD_W-1:0]         rom_data,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             overlaps,
    output logic [idx_w(N_CLAIMS)-1:0]   intact_id,
    output logic                         intact_valid
);

    localparam int IW = idx_w(N_CLAIMS);
    localparam int CW = $clog2(MIN_COVER + 1);

    localparam logic [CW-1:0]      COV_MAX = CW'(MIN_COVER);
    localparam logic [IW-1:0]      LAST_ID = IW'(N_CLAIMS - 1);
    localparam logic [COORD_W-1:0] LAST_X  = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] LAST_Y  = COORD_W'(GRID_H - 1);

    state_t state;
    state_t state_n;

    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [IW-1:0]       idx;

    // Compare stage: address context that rom_data belongs to.
    logic                p_vld;
    logic                p_last;
    logic [COORD_W-1:0]  p_x;
    logic [COORD_W-1:0]  p_y;
    logic [IW-1:0]       p_id;

    logic [CW-1:0]       cov;
    logic [CW-1:0]       cov_now;
    logic [1:0]          mk;
    logic [IW-1:0]       held;
    logic [N_CLAIMS-1:0] flags;

    claim_t              cl;
    logic                hit;
    logic                id_last;
    logic                grid_last;

    assign rom_addr  = idx;
    assign id_last   = (idx == LAST_ID);
    assign grid_last = id_last && (x == LAST_X) && (y == LAST_Y);

    always_comb begin
        cl   = '0;
        cl.x = COORD_MAX_W'(rom_data[4*COORD_W-1 -: COORD_W]);
        cl.y = COORD_MAX_W'(rom_data[3*COORD_W-1 -: COORD_W]);
        cl.w = COORD_MAX_W'(rom_data[2*COORD_W-1 -: COORD_W]);
        cl.h = COORD_MAX_W'(rom_data[COORD_W-1:0]);
    end

    claim_contains u_contains (
        .claim (cl),
        .x     (COORD_MAX_W'(p_x)),
        .y     (COORD_MAX_W'(p_y)),
        .hit   (hit)
    );

    assign cov_now = (hit && (cov != COV_MAX)) ? cov + 1'b1 : cov;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (grid_last) state_n = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                state_n = FIND;
            end
            FIND: begin
                busy = 1'b1;
                if (id_last) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x            <= '0;
            y            <= '0;
            idx          <= '0;
            p_vld        <= 1'b0;
            p_last       <= 1'b0;
            p_x          <= '0;
            p_y          <= '0;
            p_id         <= '0;
            cov          <= '0;
            mk           <= '0;
            held         <= '0;
            flags        <= '0;
            overlaps     <= '0;
            intact_id    <= '0;
            intact_valid <= 1'b0;
        end else begin
            p_vld  <= (state == SCAN);
            p_last <= id_last;
            p_x    <= x;
            p_y    <= y;
            p_id   <= idx;

            if (state == IDLE && start) begin
                x            <= '0;
                y            <= '0;
                idx          <= '0;
                cov          <= '0;
                mk           <= '0;
                flags        <= '0;
                overlaps     <= '0;
                intact_id    <= '0;
                intact_valid <= 1'b0;
            end

            if (state == SCAN) begin
                if (id_last) begin
                    idx <= '0;
                    if (x == LAST_X) begin
                        x <= '0;
                        y <= (y == LAST_Y) ? '0 : y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end else begin
                    idx <= idx + 1'b1;
                end
            end

            if (state == FIND) begin
                if (!flags[idx] && !intact_valid) begin
                    intact_id    <= idx;
                    intact_valid <= 1'b1;
                end
                idx <= id_last ? '0 : idx + 1'b1;
            end

            if (p_vld) begin
                // Overlap marking counts to 2 regardless of MIN_COVER.
                if (hit) begin
                    case (mk)
                        2'd0: begin
                            held <= p_id;
                            mk   <= 2'd1;
                        end
                        2'd1: begin
                            flags[held] <= 1'b1;
                            flags[p_id] <= 1'b1;
                            mk          <= 2'd2;
                        end
                        default: flags[p_id] <= 1'b1;
                    endcase
                end
                if (p_last) begin
                    if (cov_now == COV_MAX && overlaps != {CNT_W{1'b1}})
                        overlaps <= overlaps + 1'b1;
                    cov <= '0;
                    mk  <= '0;
                end else begin
                    cov <= cov_now;
                end
            end
        end
    end

endmodule

// File: tb/tb_claim_grid_scanner.sv
// Bench: five scanner configurations on 8x8 grids, checked against a
// cell-by-cell coverage model and hand-computed results.
module tb_claim_grid_scanner;

    localparam int G  = 8;
    localparam int NI = 5;

    typedef struct {
        int x;
        int y;
        int w;
        int h;
    } rect_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   pc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) pc <= pc + 1;

    rect_t cl [NI][4];
    int    nc [NI];
    int    mc [NI];
    int    e_ov [NI];
    int    e_id [NI];
    int    e_v [NI];
    int    e_cyc [NI];
    bit    pending [NI];

    logic [39:0] rom [NI][4];
    logic [39:0] rd [NI];

    int checks = 0;
    int failures = 0;

    logic [1:0] a0, a1, a4, i0, i1, i4;
    logic       a2, a3, i2, i3;
    logic [19:0] o0, o1, o2, o3, o4;
    logic b0, b1, b2, b3, b4;
    logic d0, d1, d2, d3, d4;
    logic v0, v1, v2, v3, v4;

    int addr [NI];
    int ov_v [NI];
    int id_v [NI];
    int bz [NI];
    int dn [NI];
    int vl [NI];

    always_comb begin
        addr[0] = int'(a0); addr[1] = int'(a1); addr[2] = int'(a2);
        addr[3] = int'(a3); addr[4] = int'(a4);
        ov_v[0] = int'(o0); ov_v[1] = int'(o1); ov_v[2] = int'(o2);
        ov_v[3] = int'(o3); ov_v[4] = int'(o4);
        id_v[0] = int'(i0); id_v[1] = int'(i1); id_v[2] = int'(i2);
        id_v[3] = int'(i3); id_v[4] = int'(i4);
        bz[0] = int'(b0); bz[1] = int'(b1); bz[2] = int'(b2);
        bz[3] = int'(b3); bz[4] = int'(b4);
        dn[0] = int'(d0); dn[1] = int'(d1); dn[2] = int'(d2);
        dn[3] = int'(d3); dn[4] = int'(d4);
        vl[0] = int'(v0); vl[1] = int'(v1); vl[2] = int'(v2);
        vl[3] = int'(v3); vl[4] = int'(v4);
    end

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) rd[k] <= rom[k][addr[k]];
    end

    claim_grid_scanner #(.GRID_W(G), .GRID_H(G), .N_CLAIMS(3),
        .COORD_W(10), .MIN_COVER(2), .CNT_W(20)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(a0),
        .rom_data(rd[0]), .busy(b0), .done(d0), .overlaps(o0),
        .intact_id(i0), .intact_valid(v0));

    claim_grid_scanner #(.GRID_W(G), .GRID_H(G), .N_CLAIMS(3),
        .COORD_W(10), .MIN_COVER(1), .CNT_W(20)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(a1),
        .rom_data(rd[1]), .busy(b1), .done(d1), .overlaps(o1),
        .intact_id(i1), .intact_valid(v1));

    claim_grid_scanner #(.GRID_W(G), .GRID_H(G), .N_CLAIMS(1),
        .COORD_W(10), .MIN_COVER(2), .CNT_W(20)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(a2),
        .rom_data(rd[2]), .busy(b2), .done(d2), .overlaps(o2),
        .intact_id(i2), .intact_valid(v2));

    claim_grid_scanner #(.GRID_W(G), .GRID_H(G), .N_CLAIMS(1),
        .COORD_W(10), .MIN_COVER(1), .CNT_W(20)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(a3),
        .rom_data(rd[3]), .busy(b3), .done(d3), .overlaps(o3),
        .intact_id(i3), .intact_valid(v3));

    claim_grid_scanner #(.GRID_W(G), .GRID_H(G), .N_CLAIMS(3),
        .COORD_W(10), .MIN_COVER(2), .CNT_W(20)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(a4),
        .rom_data(rd[4]), .busy(b4), .done(d4), .overlaps(o4),
        .intact_id(i4), .intact_valid(v4));

    task automatic check(input string name, input int k,
                         input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d actual=%0d required=%0d",
                     name, k, act, exp);
        end
    endtask

    // Coverage model: count claims on each cell directly; a claim is
    // overlapped if it shares any in-grid cell with another claim.
    function automatic void model(input int k, output int ov,
                                  output int id, output int vld);
        bit fl [4];
        int cov;
        ov = 0;
        id = 0;
        vld = 0;
        for (int i = 0; i < 4; i++) fl[i] = 1'b0;
        for (int y = 0; y < G; y++) begin
            for (int x = 0; x < G; x++) begin
                cov = 0;
                for (int i = 0; i < nc[k]; i++)
                    if (in_rect(cl[k][i], x, y)) cov++;
                if (cov >= mc[k]) ov++;
                if (cov >= 2)
                    for (int i = 0; i < nc[k]; i++)
                        if (in_rect(cl[k][i], x, y)) fl[i] = 1'b1;
            end
        end
        for (int i = nc[k] - 1; i >= 0; i--) begin
            if (!fl[i]) begin
                id = i;
                vld = 1;
            end
        end
    endfunction

    function automatic bit in_rect(input rect_t r, input int x,
                                   input int y);
        return x >= r.x && x < r.x + r.w && y >= r.y && y < r.y + r.h;
    endfunction

    function automatic rect_t mk_r(input int x, input int y,
                                   input int w, input int h);
        rect_t r;
        r.x = x;
        r.y = y;
        r.w = w;
        r.h = h;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NI; k++) begin
                if (dn[k] != 0) begin
                    check("done_expected", k, int'(pending[k]), 1);
                    if (pending[k]) begin
                        check("done_cycle", k, pc, e_cyc[k]);
                        check("overlaps", k, ov_v[k], e_ov[k]);
                        check("intact_id", k, id_v[k], e_id[k]);
                        check("intact_valid", k, vl[k], e_v[k]);
                        check("busy_at_done", k, bz[k], 0);
                        pending[k] = 1'b0;
                    end
                end else if (pending[k] && pc > e_cyc[k]) begin
                    check("done_missing", k, 0, 1);
                    pending[k] = 1'b0;
                end
            end
        end
    end

    task automatic do_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        for (int k = 0; k < NI; k++) begin
            pending[k] = 1'b1;
            e_cyc[k] = pc + G * G * nc[k] + nc[k] + 2;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic poke_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_all();
        bit any;
        any = 1'b1;
        for (int c = 0; c < 2000 && any; c++) begin
            @(negedge clk);
            #1;
            any = 1'b0;
            for (int k = 0; k < NI; k++) any |= pending[k];
        end
        for (int k = 0; k < NI; k++) begin
            if (pending[k]) begin
                check("wait_timeout", k, 0, 1);
                pending[k] = 1'b0;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < NI; k++) begin
            check({tag, "_busy"}, k, bz[k], 0);
            check({tag, "_done"}, k, dn[k], 0);
            check({tag, "_overlaps"}, k, ov_v[k], 0);
            check({tag, "_intact_id"}, k, id_v[k], 0);
            check({tag, "_intact_valid"}, k, vl[k], 0);
            check({tag, "_rom_addr"}, k, addr[k], 0);
        end
    endtask

    initial begin
        int ov, id, vld;
        for (int k = 0; k < NI; k++) begin
            pending[k] = 1'b0;
            for (int i = 0; i < 4; i++) cl[k][i] = mk_r(0, 0, 0, 0);
        end
        for (int k = 0; k < 2; k++) begin
            cl[k][0] = mk_r(1, 3, 4, 4);
            cl[k][1] = mk_r(3, 1, 4, 4);
            cl[k][2] = mk_r(5, 5, 2, 2);
            nc[k] = 3;
        end
        mc[0] = 2;
        mc[1] = 1;
        cl[2][0] = mk_r(6, 6, 4, 4);
        cl[3][0] = mk_r(6, 6, 4, 4);
        nc[2] = 1;
        nc[3] = 1;
        mc[2] = 2;
        mc[3] = 1;
        for (int i = 0; i < 3; i++) cl[4][i] = mk_r(0, 0, 2, 2);
        nc[4] = 3;
        mc[4] = 2;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 4; i++) begin
                rom[k][i] = {10'(cl[k][i].x), 10'(cl[k][i].y),
                             10'(cl[k][i].w), 10'(cl[k][i].h)};
            end
            model(k, ov, id, vld);
            e_ov[k] = ov;
            e_id[k] = id;
            e_v[k] = vld;
        end

        // Hand-computed results pin the model.
        check("pin_ov", 0, e_ov[0], 4);
        check("pin_id", 0, e_id[0], 2);
        check("pin_v", 0, e_v[0], 1);
        check("pin_ov", 1, e_ov[1], 32);
        check("pin_id", 1, e_id[1], 2);
        check("pin_ov", 2, e_ov[2], 0);
        check("pin_v", 2, e_v[2], 1);
        check("pin_ov", 3, e_ov[3], 4);
        check("pin_ov", 4, e_ov[4], 4);
        check("pin_v", 4, e_v[4], 0);
        check("pin_id", 4, e_id[4], 0);

        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Run 1, with an ignored start mid-SCAN.
        do_start();
        repeat (20) @(negedge clk);
        for (int k = 0; k < NI; k++) check("busy_mid", k, bz[k], 1);
        poke_start();
        wait_all();

        repeat (5) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("hold_overlaps", k, ov_v[k], e_ov[k]);
            check("hold_intact_id", k, id_v[k], e_id[k]);
            check("hold_valid", k, vl[k], e_v[k]);
            check("hold_done", k, dn[k], 0);
        end

        // Run 2: back-to-back repeat.
        do_start();
        wait_all();

        // Run 3: aborted by reset mid-SCAN, then a clean run.
        do_start();
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) pending[k] = 1'b0;
        #1;
        check_zero("abort");
        repeat (3) @(negedge clk);
        check_zero("abort_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_start();
        wait_all();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
